// File: rtl/misr_pkg.sv
// Shared constants and types for the response-side MISR checker and its folder.
package misr_pkg;

    localparam int unsigned DEF_DATA_W  = 159;
    localparam int unsigned DEF_SIG_W   = 32;
    localparam int unsigned DEF_CNT_W   = 32;
    localparam int unsigned FOLD_SLICES = 5;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/resp_fold.sv
// Combinational XOR folder: zero-extends a wide word to a SIG_W multiple and XORs the slices.
module resp_fold #(
    parameter int unsigned DATA_W = 159,
    parameter int unsigned SIG_W  = 32
) (
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  fold
);

    localparam int unsigned SLICES = (DATA_W + SIG_W - 1) / SIG_W;
    localparam int unsigned EXT_W  = SLICES * SIG_W;

    logic [EXT_W-1:0] ext;

    assign ext = EXT_W'(data);

    always_comb begin
        fold = '0;
        for (int unsigned i = 0; i < SLICES; i++) begin
            fold = fold ^ ext[i*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/resp_misr_checker.sv
// Compacts a response stream into a MISR over a programmed number of beats and
// compares the result against a latched golden signature.
module resp_misr_checker
    import misr_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SIG_W  = DEF_SIG_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cycles,
    input  logic [SIG_W-1:0]  expected_sig,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  count
);

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [SIG_W-1:0] exp_lat;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_next;
    logic [CNT_W-1:0] count_inc;

    resp_fold #(
        .DATA_W(DATA_W),
        .SIG_W (SIG_W)
    ) u_fold (
        .data(resp_data),
        .fold(fold)
    );

    assign sig_next  = {signature[SIG_W-2:0], 1'b0}
                     ^ (signature[SIG_W-1] ? SIG_W'(POLY) : '0)
                     ^ fold;
    assign count_inc = count + CNT_W'(1);

    // A beat arriving with an accepted start is never folded: only RUN folds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SIG_W'(SEED);
            count     <= '0;
            n_lat     <= '0;
            exp_lat   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_lat     <= num_cycles;
                        exp_lat   <= expected_sig;
                        signature <= SIG_W'(SEED);
                        count     <= '0;
                        if (num_cycles == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (expected_sig == SIG_W'(SEED));
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        signature <= sig_next;
                        count     <= count_inc;
                        if (count_inc == n_lat) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_next == exp_lat);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resp_misr_checker.sv
// Scoreboard bench for resp_misr_checker: expected run results are queued at stimulus time.
module tb_resp_misr_checker;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  num_cycles;
    logic [31:0]  expected_sig;
    logic         resp_valid;
    logic [158:0] resp_data;
    logic         busy;
    logic         done;
    logic         pass;
    logic [31:0]  signature;
    logic [31:0]  count;

    typedef struct {
        logic [31:0] sig;
        logic [31:0] cnt;
        logic        pass;
    } exp_t;

    exp_t         sb[$];
    logic [158:0] beats[0:127];
    int           n_checks = 0;
    int           n_pass   = 0;

    resp_misr_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_cycles  (num_cycles),
        .expected_sig(expected_sig),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] misr_model(input logic [31:0] s, input logic [158:0] d);
        logic [159:0] e;
        logic [31:0]  f;
        e = {1'b0, d};
        f = 32'h0;
        for (int i = 0; i < 5; i++) f = f ^ e[i*32 +: 32];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) s = misr_model(s, beats[i]);
        return s;
    endfunction

    task automatic fill_lcg(input int n, input logic [31:0] seed);
        logic [31:0]  x;
        logic [159:0] w;
        x = seed;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 5; j++) begin
                x = x * 32'h41C64E6D + 32'h3039;
                w[j*32 +: 32] = x;
            end
            beats[i] = w[158:0];
        end
    endtask

    // Start a run of n beats, optionally with one idle cycle between beats and a
    // spurious start on beat spur_idx; returns cycles from start edge to done.
    task automatic do_run(input int n, input logic [31:0] exp, input bit gaps,
                          input int spur_idx, output int cyc);
        exp_t e;
        int   guard;
        e.sig  = model_sig(n);
        e.cnt  = 32'(n);
        e.pass = (e.sig == exp);
        sb.push_back(e);

        start        = 1'b1;
        num_cycles   = 32'(n);
        expected_sig = exp;
        resp_valid   = 1'b1;
        resp_data    = ~beats[0];
        tick();
        cyc        = 1;
        start      = 1'b0;
        resp_valid = 1'b0;
        check_eq("start_sig", 64'(signature), 64'hFFFFFFFF);
        check_eq("start_cnt", 64'(count), 64'h0);
        check_eq("start_busy", 64'(busy), 64'(n != 0));
        check_eq("start_done", 64'(done), 64'(n == 0));

        for (int i = 0; i < n; i++) begin
            resp_valid = 1'b1;
            resp_data  = beats[i];
            if (i == spur_idx) begin
                start      = 1'b1;
                num_cycles = 32'd2;
            end
            tick();
            cyc++;
            start      = 1'b0;
            resp_valid = 1'b0;
            if (gaps && i < n - 1) begin
                tick();
                cyc++;
            end
        end

        guard = 0;
        while (!done && guard < 8) begin
            tick();
            cyc++;
            guard++;
        end
        check_eq("done_seen", 64'(done), 64'h1);
        check_eq("done_busy", 64'(busy), 64'h0);

        e = sb.pop_front();
        check_eq("sb_sig", 64'(signature), 64'(e.sig));
        check_eq("sb_cnt", 64'(count), 64'(e.cnt));
        check_eq("sb_pass", 64'(pass), 64'(e.pass));

        resp_valid = 1'b1;
        resp_data  = beats[0] ^ 159'h5A5A;
        tick();
        resp_valid = 1'b0;
        check_eq("done_frozen_sig", 64'(signature), 64'(e.sig));
        check_eq("done_frozen_cnt", 64'(count), 64'(e.cnt));
    endtask

    initial begin
        int          c0;
        int          c1;
        logic [31:0] m;

        rst_n        = 1'b0;
        start        = 1'b0;
        num_cycles   = 32'h0;
        expected_sig = 32'h0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        for (int i = 0; i < 128; i++) beats[i] = '0;
        tick();
        tick();
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_done", 64'(done), 64'h0);
        check_eq("rst_pass", 64'(pass), 64'h0);
        check_eq("rst_sig", 64'(signature), 64'hFFFFFFFF);
        check_eq("rst_cnt", 64'(count), 64'h0);
        rst_n = 1'b1;
        tick();

        do_run(0, 32'hFFFFFFFF, 1'b0, -1, c0);
        check_eq("zero_pass", 64'(pass), 64'h1);
        check_eq("zero_lat", 64'(c0), 64'd1);
        do_run(0, 32'h0, 1'b0, -1, c0);
        check_eq("zero_fail", 64'(pass), 64'h0);

        beats[0] = '0;
        do_run(1, 32'hFB3EE249, 1'b0, -1, c0);
        check_eq("one_sig0", 64'(signature), 64'hFB3EE249);
        check_eq("one_pass0", 64'(pass), 64'h1);
        check_eq("one_lat", 64'(c0), 64'd2);
        beats[0] = 159'h1;
        do_run(1, 32'hFB3EE249, 1'b0, -1, c0);
        check_eq("one_sig1", 64'(signature), 64'hFB3EE248);
        check_eq("one_pass1", 64'(pass), 64'h0);

        fill_lcg(8, 32'h1234_5678);
        do_run(8, 32'h0, 1'b0, -1, c0);
        m = signature;
        do_run(8, 32'h0, 1'b1, -1, c1);
        check_eq("gap_sig", 64'(signature), 64'(m));
        check_eq("gap_lat_cont", 64'(c0), 64'd9);
        check_eq("gap_delay", 64'(c1 - c0), 64'd7);

        fill_lcg(6, 32'hCAFE_0001);
        do_run(6, model_sig(6), 1'b0, 1, c0);
        check_eq("spur_lat", 64'(c0), 64'd7);
        check_eq("spur_pass", 64'(pass), 64'h1);

        fill_lcg(10, 32'h0BAD_F00D);
        start      = 1'b1;
        num_cycles = 32'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp_data  = beats[i];
            tick();
        end
        resp_valid = 1'b0;
        check_eq("mid_cnt", 64'(count), 64'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mrst_busy", 64'(busy), 64'h0);
        check_eq("mrst_done", 64'(done), 64'h0);
        check_eq("mrst_pass", 64'(pass), 64'h0);
        check_eq("mrst_sig", 64'(signature), 64'hFFFFFFFF);
        check_eq("mrst_cnt", 64'(count), 64'h0);
        for (int i = 3; i < 6; i++) begin
            resp_valid = 1'b1;
            resp_data  = beats[i];
            tick();
        end
        resp_valid = 1'b0;
        check_eq("idle_ign_sig", 64'(signature), 64'hFFFFFFFF);
        check_eq("idle_ign_cnt", 64'(count), 64'h0);
        check_eq("idle_ign_busy", 64'(busy), 64'h0);

        fill_lcg(100, 32'd2706462215);
        m = model_sig(100);
        do_run(100, m, 1'b0, -1, c0);
        check_eq("lcg_pass", 64'(pass), 64'h1);
        do_run(100, m ^ 32'h0000_0100, 1'b0, -1, c0);
        check_eq("lcg_flip", 64'(pass), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
